// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: single-outstanding FPU issue/response controller; define FPU_ISSUE_SQRT_EN to enable the sqrt core (op 6)
module fpu_issue_ctrl #(
  parameter int ADD_LAT  = 8,
  parameter int MUL_LAT  = 6,
  parameter int DIV_LAT  = 28,
  parameter int CVT_LAT  = 6,
  parameter int SQRT_LAT = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_tag,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  output logic [5:0]  core_addop,
  input  logic [31:0] add_res,
  input  logic [31:0] mul_res,
  input  logic [31:0] div_res,
  input  logic [31:0] ftoi_res,
  input  logic [31:0] itof_res,
  input  logic [31:0] sqrt_res,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_tag,
  output logic        rsp_illegal
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  state_t      r_state, w_next;
  logic [5:0]  r_cnt, w_lat;
  logic [2:0]  r_op;
  logic        r_ready, w_illegal, w_accept;
  logic [31:0] w_core_res;
  assign w_accept = (r_state == IDLE) && req_valid;
`ifdef FPU_ISSUE_SQRT_EN
  assign w_illegal  = req_op == 3'd7;
  assign w_lat      = (req_op[2:1] == 2'd0) ? 6'(ADD_LAT) :
                      (req_op == 3'd2)      ? 6'(MUL_LAT) :
                      (req_op == 3'd3)      ? 6'(DIV_LAT) :
                      (req_op == 3'd6)      ? 6'(SQRT_LAT) : 6'(CVT_LAT);
  assign w_core_res = (r_op[2:1] == 2'd0) ? add_res :
                      (r_op == 3'd2)      ? mul_res :
                      (r_op == 3'd3)      ? div_res :
                      (r_op == 3'd4)      ? ftoi_res :
                      (r_op == 3'd5)      ? itof_res : sqrt_res;
`else
  logic w_unused_sqrt;
  assign w_unused_sqrt = (^sqrt_res) ^ (SQRT_LAT == 0);
  assign w_illegal  = req_op[2:1] == 2'd3;
  assign w_lat      = (req_op[2:1] == 2'd0) ? 6'(ADD_LAT) :
                      (req_op == 3'd2)      ? 6'(MUL_LAT) :
                      (req_op == 3'd3)      ? 6'(DIV_LAT) : 6'(CVT_LAT);
  assign w_core_res = (r_op[2:1] == 2'd0) ? add_res :
                      (r_op == 3'd2)      ? mul_res :
                      (r_op == 3'd3)      ? div_res :
                      (r_op == 3'd4)      ? ftoi_res : itof_res;
`endif
  assign req_ready = r_ready;
  assign rsp_valid = r_state == DONE;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // next state: illegal ops skip the latency wait entirely
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = req_valid ? (w_illegal ? DONE : WAIT) : IDLE;
      WAIT:    w_next = (r_cnt == 6'd0) ? DONE : WAIT;
      DONE:    w_next = rsp_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // operand/tag capture on accept, latency countdown and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready     <= 1'b0;
      r_cnt       <= 6'd0;
      r_op        <= 3'd0;
      core_a      <= 32'd0;
      core_b      <= 32'd0;
      core_addop  <= 6'd0;
      rsp_result  <= 32'd0;
      rsp_tag     <= 5'd0;
      rsp_illegal <= 1'b0;
    end else begin
      r_ready <= w_next == IDLE;
      if (w_accept) begin
        core_a      <= req_a;
        core_b      <= req_b;
        core_addop  <= {5'd0, req_op == 3'd1};
        r_op        <= req_op;
        rsp_tag     <= req_tag;
        r_cnt       <= w_illegal ? 6'd0 : w_lat;
        rsp_illegal <= w_illegal;
        if (w_illegal) rsp_result <= QNAN;
      end else if (r_state == WAIT) begin
        if (r_cnt == 6'd0) rsp_result <= w_core_res;
        else               r_cnt <= r_cnt - 6'd1;
      end
    end
  end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed self-checking bench for fpu_issue_ctrl
module tb_fpu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, rsp_valid, rsp_ready, rsp_illegal;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b, core_a, core_b, rsp_result;
  logic [31:0] add_res, mul_res, div_res, ftoi_res, itof_res, sqrt_res;
  logic [4:0]  req_tag, rsp_tag;
  logic [5:0]  core_addop;
  int errors = 0;
  int checks = 0;
`ifdef FPU_ISSUE_SQRT_EN
  localparam int          SQ_N = 29;
  localparam logic [31:0] SQ_R = 32'h4000_0000;
  localparam logic        SQ_I = 1'b0;
`else
  localparam int          SQ_N = 0;
  localparam logic [31:0] SQ_R = 32'h7FC0_0000;
  localparam logic        SQ_I = 1'b1;
`endif

  fpu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .core_a(core_a), .core_b(core_b), .core_addop(core_addop),
    .add_res(add_res), .mul_res(mul_res), .div_res(div_res),
    .ftoi_res(ftoi_res), .itof_res(itof_res), .sqrt_res(sqrt_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  task automatic set_cores(input logic [31:0] ad, mu, dv, ft, it, sq);
    add_res = ad; mul_res = mu; div_res = dv; ftoi_res = ft; itof_res = it; sqrt_res = sq;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, b, input logic [4:0] tag);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = 32'hDEAD_BEEF; req_b = 32'hCAFE_F00D; req_tag = 5'h15;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_op = 3'd0;
    req_a = 32'd0; req_b = 32'd0; req_tag = 5'd0;
    set_cores(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if ({core_a, core_b, core_addop} !== 70'd0) begin errors++; $display("FAIL reset_core got %h %h %h exp 0", core_a, core_b, core_addop); end
    checks++; if ({rsp_result, rsp_tag, rsp_illegal} !== 38'd0) begin errors++; $display("FAIL reset_rsp got %h %h %b exp 0", rsp_result, rsp_tag, rsp_illegal); end
    #21 rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b exp 0", req_ready); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge got %b exp 1", req_ready); end
  endtask

  task automatic test_add();
    int n;
    set_cores(32'h4040_0000, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6);
    issue(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd5);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL add_ready got %b exp 0", req_ready); end
    checks++; if ({core_a, core_b} !== {32'h3F80_0000, 32'h4000_0000}) begin errors++; $display("FAIL add_core got %h %h exp 3f800000 40000000", core_a, core_b); end
    checks++; if (core_addop !== 6'd0) begin errors++; $display("FAIL add_addop got %0d exp 0", core_addop); end
    wait_rsp(n);
    checks++; if (n !== 9) begin errors++; $display("FAIL add_latency got %0d exp 9", n); end
    checks++; if (rsp_result !== 32'h4040_0000) begin errors++; $display("FAIL add_result got %h exp 40400000", rsp_result); end
    checks++; if ({rsp_tag, rsp_illegal} !== {5'd5, 1'b0}) begin errors++; $display("FAIL add_tag got %0d %b exp 5 0", rsp_tag, rsp_illegal); end
    handshake();
    checks++; if ({req_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL add_release got %b%b exp 10", req_ready, rsp_valid); end
  endtask

  task automatic test_sub();
    int n;
    set_cores(32'h4000_0000, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6);
    issue(3'd1, 32'h4040_0000, 32'h3F80_0000, 5'd9);
    checks++; if (core_addop !== 6'd1) begin errors++; $display("FAIL sub_addop_start got %0d exp 1", core_addop); end
    wait_rsp(n);
    checks++; if (n !== 9) begin errors++; $display("FAIL sub_latency got %0d exp 9", n); end
    checks++; if (rsp_result !== 32'h4000_0000) begin errors++; $display("FAIL sub_result got %h exp 40000000", rsp_result); end
    handshake();
    repeat (3) @(posedge clk); #1;
    checks++; if ({core_addop, core_a} !== {6'd1, 32'h4040_0000}) begin errors++; $display("FAIL sub_hold got %0d %h exp 1 40400000", core_addop, core_a); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [3] = '{3'd2, 3'd4, 3'd5};
    logic [31:0] res [3] = '{32'h40C0_0000, 32'h0000_0007, 32'h4100_0000};
    int n;
    for (int i = 0; i < 3; i++) begin
      set_cores(32'hC1, (i == 0) ? res[0] : 32'hC2, 32'hC3, (i == 1) ? res[1] : 32'hC4, (i == 2) ? res[2] : 32'hC5, 32'hC6);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b exp 1", i, req_ready); end
      issue(ops[i], 32'h1000 + i, 32'h2000 + i, 5'(i + 1));
      checks++; if ({req_ready, core_a} !== {1'b0, 32'h1000 + i}) begin errors++; $display("FAIL b2b_accept%0d got %b %h", i, req_ready, core_a); end
      wait_rsp(n);
      checks++; if (n !== 7) begin errors++; $display("FAIL b2b_latency%0d got %0d exp 7", i, n); end
      checks++; if ({rsp_result, rsp_tag} !== {res[i], 5'(i + 1)}) begin errors++; $display("FAIL b2b_result%0d got %h %0d exp %h %0d", i, rsp_result, rsp_tag, res[i], i + 1); end
      handshake();
    end
  endtask

  task automatic test_stall();
    int n;
    set_cores(32'hD1, 32'hD2, 32'h3EAA_AAAB, 32'hD4, 32'hD5, 32'hD6);
    issue(3'd3, 32'h3F80_0000, 32'h4040_0000, 5'd7);
    wait_rsp(n);
    checks++; if (n !== 29) begin errors++; $display("FAIL div_latency got %0d exp 29", n); end
    div_res = 32'h0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin req_valid = 1'b1; req_op = 3'd0; req_a = 32'h1234_5678; req_tag = 5'h1A; end
      @(posedge clk); #1;
      checks++; if ({rsp_valid, req_ready} !== 2'b10) begin errors++; $display("FAIL stall_flags%0d got %b%b exp 10", i, rsp_valid, req_ready); end
      checks++; if ({rsp_result, rsp_tag, rsp_illegal} !== {32'h3EAA_AAAB, 5'd7, 1'b0}) begin errors++; $display("FAIL stall_hold%0d got %h %0d %b", i, rsp_result, rsp_tag, rsp_illegal); end
    end
    req_valid = 1'b0;
    handshake();
    checks++; if ({req_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL stall_release got %b%b exp 10", req_ready, rsp_valid); end
    checks++; if ({core_a, core_b} !== {32'h3F80_0000, 32'h4040_0000}) begin errors++; $display("FAIL stall_ignored got %h %h", core_a, core_b); end
  endtask

  task automatic test_illegal();
    issue(3'd7, 32'h1, 32'h2, 5'h1F);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL ill_valid got %b exp 1", rsp_valid); end
    checks++; if ({rsp_result, rsp_illegal, rsp_tag} !== {32'h7FC0_0000, 1'b1, 5'h1F}) begin errors++; $display("FAIL ill_rsp got %h %b %0d", rsp_result, rsp_illegal, rsp_tag); end
    handshake();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ill_release got %b exp 1", req_ready); end
  endtask

  task automatic test_reset_mid();
    int n, seen;
    set_cores(32'hE1, 32'hE2, 32'hE3, 32'hE4, 32'h4040_0000, 32'hE6);
    issue(3'd3, 32'h4110_0000, 32'h4040_0000, 5'd3);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({req_ready, rsp_valid, rsp_illegal} !== 3'b000) begin errors++; $display("FAIL midrst_flags got %b%b%b exp 000", req_ready, rsp_valid, rsp_illegal); end
    checks++; if ({core_a, core_b, core_addop, rsp_result, rsp_tag} !== 107'd0) begin errors++; $display("FAIL midrst_data got %h %h %h %h", core_a, core_b, rsp_result, rsp_tag); end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_rsp got %0d exp 0", seen); end
    issue(3'd5, 32'h0000_0003, 32'h0, 5'd12);
    wait_rsp(n);
    checks++; if ({n, rsp_result, rsp_tag} !== {32'd7, 32'h4040_0000, 5'd12}) begin errors++; $display("FAIL itof got %0d %h %0d exp 7 40400000 12", n, rsp_result, rsp_tag); end
    handshake();
  endtask

  task automatic test_sqrt();
    int n;
    set_cores(32'hF1, 32'hF2, 32'hF3, 32'hF4, 32'hF5, 32'h4000_0000);
    issue(3'd6, 32'h4080_0000, 32'h0, 5'd4);
    wait_rsp(n);
    checks++; if (n !== SQ_N) begin errors++; $display("FAIL sqrt_latency got %0d exp %0d", n, SQ_N); end
    checks++; if ({rsp_result, rsp_illegal, rsp_tag} !== {SQ_R, SQ_I, 5'd4}) begin errors++; $display("FAIL sqrt_rsp got %h %b %0d exp %h %b 4", rsp_result, rsp_illegal, rsp_tag, SQ_R, SQ_I); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_sqrt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameters SHALL be: ADD_LAT, 8, adder/subtract latency (1..62); MUL_LAT, 6, multiplier latency; DIV_LAT, 28, divider latency; CVT_LAT, 6, ftoi/itof latency; SQRT_LAT, 28, sqrt latency.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  async active-low reset.
REQ-005 req_valid  in  1  request present; req_ready  out  1  controller accepts.
REQ-006 req_op  in  3  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 FTOI, 5 ITOF, 6 SQRT, 7 illegal.
REQ-007 req_a, req_b  in  32  operands (IEEE-754 single, or int32 for ITOF); req_tag  in  5  caller tag.
REQ-008 core_a, core_b  out  32  operand buses to all FPU cores; core_addop  out  6  adder operation (6'd0 add, 6'd1 sub).
REQ-009 add_res, mul_res, div_res, ftoi_res, itof_res, sqrt_res  in  32  core results.
REQ-010 rsp_valid  out  1; rsp_ready  in  1; rsp_result  out  32; rsp_tag  out  5; rsp_illegal  out  1.

Function
REQ-011 FSM SHALL have states IDLE, WAIT, DONE; req_ready SHALL be 1 only in IDLE.
REQ-012 Accept SHALL occur on an edge with req_valid=1 and state IDLE; on that edge core_a, core_b, core_addop, op, tag register and cnt loads LAT for the op.
REQ-013 core_a, core_b, core_addop SHALL hold unchanged from accept until the next accept or reset.
REQ-014 In WAIT cnt SHALL decrement by 1 per cycle; on the edge where cnt==0 the result mux SHALL capture the op's core result into rsp_result and state goes DONE.
REQ-015 rsp_valid SHALL rise exactly LAT+1 cycles after the accepting edge and SHALL be 1 only in DONE.
REQ-016 rsp_result, rsp_tag, rsp_illegal SHALL be stable while rsp_valid=1 and rsp_ready=0 (indefinite stall allowed).
REQ-017 DONE with rsp_ready=1 SHALL go IDLE next edge; req_ready SHALL be 1 the cycle after the response handshake.
REQ-018 One operation outstanding at most; minimum request-to-request spacing SHALL be LAT+3 cycles.
REQ-019 req_op=7 SHALL bypass WAIT: accept edge goes directly DONE with rsp_result=32'h7FC00000, rsp_illegal=1.
REQ-020 rsp_illegal SHALL be 0 for every legal op; req_valid in WAIT/DONE SHALL be ignored (not captured).
REQ-021 cnt width SHALL be 6 bits; no wrap occurs (loaded value never below 0 reached without capture).

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, cnt=0, core_a=core_b=0, core_addop=0, rsp_result=0, rsp_tag=0, rsp_illegal=0, rsp_valid=0, req_ready=0.
REQ-023 After rst_n deasserts, req_ready SHALL be 1 from the first clock edge onward in IDLE.
REQ-024 Reset during WAIT or DONE SHALL discard the operation; no response is produced for it.

Configuration
REQ-025 Macro FPU_ISSUE_SQRT_EN defined: op 6 SHALL issue to the sqrt core with SQRT_LAT and return sqrt_res, rsp_illegal=0.
REQ-026 Macro FPU_ISSUE_SQRT_EN undefined: op 6 SHALL behave exactly as op 7 (REQ-019), sqrt_res SHALL be ignored, SQRT_LAT unused.

Verification
REQ-027 ADD a=3F800000 b=40000000 tag=5, core model returns a+b after 8 cycles -> rsp_valid at accept+9, rsp_result=40400000, rsp_tag=5, rsp_illegal=0.
REQ-028 SUB a=40400000 b=3F800000 -> core_addop=6'd1 held throughout, rsp_result=40000000.
REQ-029 DIV accepted, rsp_ready held 0 for 10 cycles after rsp_valid -> rsp fields stable, req_ready=0, second req_valid ignored; rsp_ready=1 -> req_ready=1 next cycle.
REQ-030 req_op=7 -> rsp_valid the cycle after accept, rsp_result=7FC00000, rsp_illegal=1.
REQ-031 DIV accepted, rst_n pulsed low at accept+10 -> rsp_valid never asserts for it, all outputs 0 during reset, new ITOF a=00000003 later returns 40400000.
REQ-032 SQRT a=40800000 with and without FPU_ISSUE_SQRT_EN -> 40000000 at accept+29 vs 7FC00000/rsp_illegal=1 at accept+1.
